fifo_sc_param: RTL

- Single-clock, parametrised successor to the team's dual-clock FIFO.
- Configurable width and depth, programmable almost-full/almost-empty thresholds, standard or first-word-fall-through (FWFT) read mode, and sticky overflow/underflow error flags.
- Used as the general buffering primitive between same-clock pipeline stages. It replaces ad-hoc fixed-width 8-bit buffers.

---
 rtl/fifo_sc_param_if.sv | 33 +++
 rtl/fifo_sc_param.sv | 125 ++++++++++++
 2 files changed

// File: rtl/fifo_sc_param_if.sv
// Bundle of the handshake, data and status signals of the single-clock FIFO.
// The master side (producer/consumer logic) drives requests and write data.
// The slave side (the FIFO itself) drives read data and occupancy/error status.
interface fifo_sc_param_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int CW   = $clog2(DEPTH + 1)
) ();
    logic             wr_en;
    logic             re_en;
    logic [WIDTH-1:0] buf_in;
    logic             err_clr;
    logic [WIDTH-1:0] buf_out;
    logic [CW-1:0]    count;
    logic             buf_full;
    logic             buf_emp;
    logic             almost_full;
    logic             almost_emp;
    logic             overflow;
    logic             underflow;

    modport master (
        output wr_en, re_en, buf_in, err_clr,
        input  buf_out, count, buf_full, buf_emp,
        input  almost_full, almost_emp, overflow, underflow
    );

    modport slave (
        input  wr_en, re_en, buf_in, err_clr,
        output buf_out, count, buf_full, buf_emp,
        output almost_full, almost_emp, overflow, underflow
    );
endinterface

// File: rtl/fifo_sc_param.sv
// Single-clock parametrised FIFO with programmable almost-full/almost-empty
// levels, standard or first-word-fall-through read data, and sticky
// overflow/underflow flags. Depth need not be a power of two: the pointers
// wrap on an explicit compare against the last entry.
module fifo_sc_param #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int AF_LVL = DEPTH - 2,
    parameter int AE_LVL = 2,
    parameter int FWFT   = 0,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic           clk,
    input  logic           rst,
    fifo_sc_param_if.slave bus
);
    localparam int            PW       = $clog2(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LVL);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_LVL);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] buf_q, buf_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             full_s, emp_s;
    logic             wr_acc_s, rd_acc_s;
    logic [WIDTH-1:0] fwft_data_s;

    // Advance a storage pointer by one entry, wrapping after the last entry.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] r;
        if (p == LAST_PTR) begin
            r = '0;
        end else begin
            r = p + PW'(1);
        end
        return r;
    endfunction

    assign full_s = (count_q == FULL_CNT);
    assign emp_s  = (count_q == '0);

    // Accept decisions and next-state values for pointers, count, read data and error flags.
    always_comb begin
        rd_acc_s = bus.re_en & ~emp_s;
        // A full FIFO still takes a write when a read frees a slot in the same cycle.
        wr_acc_s = bus.wr_en & (~full_s | rd_acc_s);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        buf_d    = buf_q;
        if (wr_acc_s) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_acc_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
            buf_d    = mem_q[rd_ptr_q];
        end else begin
            rd_ptr_d = rd_ptr_q;
            buf_d    = buf_q;
        end

        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A new error in the same cycle as err_clr keeps the flag set.
        ovf_d = (ovf_q & ~bus.err_clr) | (bus.wr_en & ~wr_acc_s);
        unf_d = (unf_q & ~bus.err_clr) | (bus.re_en & ~rd_acc_s);
    end

    // Control state registers; reset discards all stored data.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            buf_q    <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            buf_q    <= buf_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage array write; contents are deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc_s) begin
            mem_q[wr_ptr_q] <= bus.buf_in;
        end
    end

    // Fall-through data: head entry while occupied, zero when empty.
    always_comb begin
        fwft_data_s = '0;
        if (emp_s) begin
            fwft_data_s = '0;
        end else begin
            fwft_data_s = mem_q[rd_ptr_q];
        end
    end

    assign bus.buf_out     = (FWFT != 0) ? fwft_data_s : buf_q;
    assign bus.count       = count_q;
    assign bus.buf_full    = full_s;
    assign bus.buf_emp     = emp_s;
    assign bus.almost_full = (count_q >= AF_CNT);
    assign bus.almost_emp  = (count_q <= AE_CNT);
    assign bus.overflow    = ovf_q;
    assign bus.underflow   = unf_q;
endmodule
